// File: rtl/spi_slave_port_if.sv
// spi_slave_port_if
// Local-side bus of the SPI slave port: the one-entry TX buffer handshake,
// the RX word handshake, the sticky status flags and the interrupt line.
//
// Signals:
//   tx_data/tx_valid/tx_ready  word queued for the next SPI frame
//   rx_data/rx_valid/rx_ready  last complete word received from the master
//   status                     sticky {frame_err, rx_overrun, tx_underrun}
//   status_clr                 single-cycle pulse clearing status
//   spi_irq                    rx_valid OR any status bit
//
// Modports: slave (the port itself), master (the local host driving it).
interface spi_slave_port_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [2:0]            status;
    logic                  status_clr;
    logic                  spi_irq;

    modport slave (
        input  tx_data, tx_valid, rx_ready, status_clr,
        output tx_ready, rx_data, rx_valid, status, spi_irq
    );

    modport master (
        output tx_data, tx_valid, rx_ready, status_clr,
        input  tx_ready, rx_data, rx_valid, status, spi_irq
    );
endinterface

// File: rtl/spi_slave_port.sv
// spi_slave_port
// SPI mode-0 slave, MSB first, oversampled by the system clock (clk must be
// at least 4x sclk). sclk, ss and mosi are synchronized into the clk domain
// and edges are found by comparing consecutive synchronized samples.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   sclk, ss, mosi  SPI inputs from the master (ss active low)
//   miso, miso_oe   SPI output and its enable (0 while idle)
//   bus             local-side handshakes, status and irq (slave modport)
module spi_slave_port #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    spi_slave_port_if.slave   bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_prev, ss_prev;
    logic [SYNC_STAGES:0]   ss_vld;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;

    logic [CNT_W-1:0]      cnt;
    logic                  cnt_full;
    logic [DATA_WIDTH-1:0] rx_shift, tx_shift, tx_buf, rx_data;
    logic                  tx_full, rx_valid, tx_write;
    logic [2:0]            status, status_set;

    logic start_frame, abort_frame, frame_done, shift_in, shift_out;

    // ss_vld marks which synchronized ss samples were taken after reset, so
    // an ss already low across reset is never mistaken for a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
            ss_vld    <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            ss_prev   <= ss_sync[SYNC_STAGES-1];
            ss_vld    <= {ss_vld[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ss_fall   = ss_vld[SYNC_STAGES] & ss_prev & ~ss_s;
    assign ss_rise   = ss_vld[SYNC_STAGES] & ~ss_prev & ss_s;
    assign cnt_full  = (cnt == CNT_W'(DATA_WIDTH));
    assign tx_write  = bus.tx_valid & ~tx_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A completed word wins over a coincident ss rise; the rise is still
    // honoured so the FSM never waits in DONE for an edge already seen.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        abort_frame = 1'b0;
        frame_done  = 1'b0;
        shift_in    = 1'b0;
        shift_out   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    start_frame = 1'b1;
                    state_next  = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cnt_full) begin
                    frame_done = 1'b1;
                    state_next = ss_rise ? IDLE : DONE;
                end else if (ss_rise) begin
                    abort_frame = 1'b1;
                    state_next  = IDLE;
                end else begin
                    shift_in  = sclk_rise;
                    shift_out = sclk_fall;
                end
            end
            DONE: begin
                if (ss_rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // At frame start a full buffer is moved into tx_shift; otherwise a write
    // landing in that same cycle goes straight to tx_shift and never fills it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            tx_buf   <= '0;
            tx_full  <= 1'b0;
        end else if (start_frame) begin
            cnt      <= '0;
            rx_shift <= '0;
            if (tx_full) begin
                tx_shift <= tx_buf;
                tx_full  <= 1'b0;
            end else if (tx_write) begin
                tx_shift <= bus.tx_data;
            end else begin
                tx_shift <= '0;
            end
        end else begin
            if (tx_write) begin
                tx_buf  <= bus.tx_data;
                tx_full <= 1'b1;
            end
            if (abort_frame) begin
                cnt      <= '0;
                tx_shift <= '0;
            end
            if (shift_in) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                cnt      <= cnt + CNT_W'(1);
            end
            if (shift_out) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // A completing word is dropped only if the previous one is still unread
    // and not being consumed in this very cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (frame_done && !(rx_valid && !bus.rx_ready)) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
        end else if (rx_valid && bus.rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    assign status_set = {abort_frame,
                         frame_done & rx_valid & ~bus.rx_ready,
                         start_frame & ~tx_full & ~tx_write};

    // Sets are OR-ed in after the clear so a same-cycle event survives it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) status <= '0;
        else     status <= (bus.status_clr ? 3'b000 : status) | status_set;
    end

    assign miso_oe      = (state != IDLE);
    assign miso         = miso_oe & tx_shift[DATA_WIDTH-1];
    assign bus.tx_ready = ~tx_full;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.status   = status;
    assign bus.spi_irq  = rx_valid | (|status);

endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port
// Drives whole SPI frames at clk/8 and checks them against a frame-level
// model of the port: TX buffer occupancy, RX word/valid and sticky flags.
module tb_spi_slave_port;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic ss = 1'b1;
    logic mosi = 1'b0;
    logic miso, miso_oe;

    int checks = 0;
    int errors = 0;

    logic          mTxFull = 1'b0;
    logic [DW-1:0] mTxBuf = '0;
    logic          mRxValid = 1'b0;
    logic [DW-1:0] mRxData = '0;
    logic [2:0]    mStatus = 3'b000;

    spi_slave_port_if #(.DATA_WIDTH(DW)) bus ();

    spi_slave_port #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk),
        .ss      (ss),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_status", 64'(bus.status), 64'(0));
        checkOutput("rst_rx_valid", 64'(bus.rx_valid), 64'(0));
        checkOutput("rst_rx_data", 64'(bus.rx_data), 64'(0));
        checkOutput("rst_tx_ready", 64'(bus.tx_ready), 64'(1));
        checkOutput("rst_miso", 64'(miso), 64'(0));
        checkOutput("rst_miso_oe", 64'(miso_oe), 64'(0));
        checkOutput("rst_spi_irq", 64'(bus.spi_irq), 64'(0));
    endtask

    task automatic checkState();
        checkOutput("rx_valid", 64'(bus.rx_valid), 64'(mRxValid));
        if (mRxValid) checkOutput("rx_data", 64'(bus.rx_data), 64'(mRxData));
        checkOutput("status", 64'(bus.status), 64'(mStatus));
        checkOutput("spi_irq", 64'(bus.spi_irq), 64'(mRxValid | (|mStatus)));
        checkOutput("tx_ready", 64'(bus.tx_ready), 64'(!mTxFull));
        checkOutput("idle_miso_oe", 64'(miso_oe), 64'(0));
        checkOutput("idle_miso", 64'(miso), 64'(0));
    endtask

    task automatic writeTx(input logic [DW-1:0] w);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        if (!mTxFull) begin
            mTxFull = 1'b1;
            mTxBuf  = w;
        end
    endtask

    task automatic popRx();
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        mRxValid = 1'b0;
    endtask

    task automatic statusClr();
        bus.status_clr = 1'b1;
        @(negedge clk);
        bus.status_clr = 1'b0;
        mStatus = 3'b000;
    endtask

    // One SPI frame of nbits bits in mode 0; miso is sampled just before
    // each rising sclk, as a master would.
    task automatic applyStimulus(input logic [DW-1:0] w, input int nbits,
                                 input bit doBypass, input logic [DW-1:0] bw,
                                 input bit readyAtDone, input int rstAtBit,
                                 output logic [DW-1:0] misoWord, output logic bypassReady);
        misoWord = '0;
        ss = 1'b0;
        repeat (2) @(negedge clk);
        if (doBypass) begin
            bus.tx_data  = bw;
            bus.tx_valid = 1'b1;
        end
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bypassReady = bus.tx_ready;
        repeat (5) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[DW-1-i];
            repeat (4) @(negedge clk);
            if (rstAtBit == i) begin
                rst = 1'b1;
                #1;
                checkReset();
                @(negedge clk);
                rst = 1'b0;
            end
            misoWord[DW-1-i] = miso;
            sclk = 1'b1;
            if (readyAtDone && i == DW-1) begin
                repeat (3) @(negedge clk);
                bus.rx_ready = 1'b1;
                @(negedge clk);
                bus.rx_ready = 1'b0;
            end else begin
                repeat (4) @(negedge clk);
            end
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        mosi = 1'b0;
        ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic runFrame(input logic [DW-1:0] w, input int nbits,
                            input bit doBypass, input logic [DW-1:0] bw,
                            input bit readyAtDone, input int rstAtBit);
        logic [DW-1:0] expMiso, gotMiso;
        logic          bypassReady;
        bit            bypassTaken;
        bypassTaken = 1'b0;
        if (mTxFull) begin
            expMiso = mTxBuf;
            mTxFull = 1'b0;
        end else if (doBypass) begin
            expMiso = bw;
            bypassTaken = 1'b1;
        end else begin
            expMiso = '0;
            mStatus[0] = 1'b1;
        end
        applyStimulus(w, nbits, doBypass, bw, readyAtDone, rstAtBit, gotMiso, bypassReady);
        if (bypassTaken) checkOutput("bypass_tx_ready", 64'(bypassReady), 64'(1));
        if (rstAtBit >= 0) begin
            mTxFull  = 1'b0;
            mRxValid = 1'b0;
            mRxData  = '0;
            mStatus  = 3'b000;
        end else if (nbits < DW) begin
            mStatus[2] = 1'b1;
        end else begin
            checkOutput("miso_word", 64'(gotMiso), 64'(expMiso));
            if (mRxValid && !readyAtDone) begin
                mStatus[1] = 1'b1;
            end else begin
                mRxData  = w;
                mRxValid = 1'b1;
            end
        end
        checkState();
    endtask

    initial begin
        bus.tx_data    = '0;
        bus.tx_valid   = 1'b0;
        bus.rx_ready   = 1'b0;
        bus.status_clr = 1'b0;
        repeat (3) @(negedge clk);
        checkReset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        $display("[TB] reset released");

        writeTx(32'hA5A5_0F0F);
        checkOutput("tx_ready_after_write", 64'(bus.tx_ready), 64'(0));
        runFrame(32'h1234_5678, DW, 0, '0, 0, -1);

        popRx();
        runFrame(32'hCAFE_0001, DW, 0, '0, 0, -1);
        statusClr();
        checkOutput("clr_status", 64'(bus.status), 64'(0));
        checkOutput("clr_spi_irq", 64'(bus.spi_irq), 64'(bus.rx_valid));
        checkOutput("clr_spi_irq_hi", 64'(bus.spi_irq), 64'(1));

        popRx();
        writeTx(32'h1111_2222);
        runFrame(32'h0000_0001, DW, 0, '0, 0, -1);
        writeTx(32'h3333_4444);
        runFrame(32'h0000_0002, DW, 0, '0, 0, -1);

        statusClr();
        writeTx(32'h5555_6666);
        runFrame(32'h0000_0003, DW, 0, '0, 1, -1);

        popRx();
        statusClr();
        writeTx(32'h7777_8888);
        runFrame(32'hFFFF_0000, 10, 0, '0, 0, -1);
        writeTx(32'h0BAD_F00D);
        runFrame(32'hDEAD_BEEF, DW, 0, '0, 0, -1);

        popRx();
        statusClr();
        runFrame(32'h2468_ACE0, DW, 1, 32'h1357_9BDF, 0, -1);

        popRx();
        writeTx(32'h9999_AAAA);
        runFrame(32'h0F0F_F0F0, DW, 0, '0, 0, 20);
        writeTx(32'hBBBB_CCCC);
        runFrame(32'h8765_4321, DW, 0, '0, 0, -1);

        for (int k = 0; k < 16; k++) begin
            int nb;
            if ($urandom_range(0, 3) != 0) writeTx($urandom);
            if ($urandom_range(0, 1) == 0) popRx();
            if ($urandom_range(0, 3) == 0) statusClr();
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, DW-1)) : DW;
            runFrame($urandom, nb, 0, '0, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
